// File: rtl/cpu.sv
// ---------------------------------------------------------------------------
// cpu: single-cycle RV32I-subset core, byte-serial loader, byte-wide readout.
// Define CPU_MUL_EN to add MUL (low 32 bits of product).         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module cpu (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [7:0] instr_i,
  input  logic       DataOrReg,
  input  logic [4:0] address,
  input  logic [1:0] vout_addr,
  output logic [7:0] value_o,
  output logic       is_positive,
  output logic [2:0] easter_egg
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CNT  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;
  localparam logic [7:0] C_SYNC = 8'hFE;

  logic [2:0]  state_q, state_d;
  logic [6:0]  n_q;
  logic [7:0]  ptr_q;
  logic [23:0] sh_q;
  logic [31:0] pc_q;
  logic [31:0] imem [64];
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [32];

  logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, mem_addr, next_pc, wb_val, src;
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        wb_en, st_en, halt, cnt_ok, load_last;
  logic        unused_bits;

  assign ins   = imem[pc_q[7:2]];
  assign opc   = ins[6:0];
  assign rd    = ins[11:7];
  assign f3    = ins[14:12];
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign f7    = ins[31:25];
  assign a     = regs_q[rs1];
  assign b     = regs_q[rs2];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  assign mem_addr = a + ((opc == 7'b0100011) ? imm_s : imm_i);
  assign unused_bits = ^{mem_addr[31:7], mem_addr[1:0]};

  always_comb begin
    wb_en   = 1'b0;
    st_en   = 1'b0;
    wb_val  = '0;
    next_pc = pc_q + 32'd4;
    case (opc)
      7'b0110011: begin
        wb_en = 1'b1;
        case ({f7, f3})
          {7'h00, 3'b000}: wb_val = a + b;
          {7'h20, 3'b000}: wb_val = a - b;
          {7'h00, 3'b111}: wb_val = a & b;
          {7'h00, 3'b110}: wb_val = a | b;
          {7'h00, 3'b100}: wb_val = a ^ b;
          {7'h00, 3'b010}: wb_val = {31'd0, $signed(a) < $signed(b)};
          {7'h00, 3'b001}: wb_val = a << b[4:0];
          {7'h00, 3'b101}: wb_val = a >> b[4:0];
`ifdef CPU_MUL_EN
          {7'h01, 3'b000}: wb_val = a * b;
`endif
          default:         wb_en  = 1'b0;
        endcase
      end
      7'b0010011: begin
        wb_en = 1'b1;
        case (f3)
          3'b000:  wb_val = a + imm_i;
          3'b111:  wb_val = a & imm_i;
          3'b110:  wb_val = a | imm_i;
          3'b100:  wb_val = a ^ imm_i;
          3'b010:  wb_val = {31'd0, $signed(a) < $signed(imm_i)};
          3'b001:  begin wb_val = a << rs2; wb_en = (f7 == 7'h00); end
          3'b101:  begin wb_val = a >> rs2; wb_en = (f7 == 7'h00); end
          default: wb_en = 1'b0;
        endcase
      end
      7'b0000011: begin
        wb_en  = (f3 == 3'b010);
        wb_val = dmem_q[mem_addr[6:2]];
      end
      7'b0100011: st_en = (f3 == 3'b010);
      7'b1100011: begin
        case (f3)
          3'b000:  if (a == b) next_pc = pc_q + imm_b;
          3'b001:  if (a != b) next_pc = pc_q + imm_b;
          3'b100:  if ($signed(a) < $signed(b)) next_pc = pc_q + imm_b;
          default: ;
        endcase
      end
      7'b1101111: begin
        wb_en   = 1'b1;
        wb_val  = pc_q + 32'd4;
        next_pc = pc_q + imm_j;
      end
      default: ;
    endcase
  end

  // Negative next PC is also caught by the unsigned bound compare; kept explicit for clarity.
  assign halt      = next_pc[31] | (|next_pc[1:0]) | (next_pc >= {23'd0, n_q, 2'b00});
  assign cnt_ok    = (instr_i != 8'd0) && (instr_i <= 8'd64);
  assign load_last = ({1'b0, ptr_q} == ({n_q, 2'b00} - 9'd1));
  assign src       = DataOrReg ? regs_q[address] : dmem_q[address];

  always_ff @(posedge clk_i) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_i == C_SYNC) state_d = S_CNT;
      S_CNT:   state_d = cnt_ok ? S_LOAD : S_IDLE;
      S_LOAD:  if (load_last) state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  if (instr_i == C_SYNC) state_d = S_CNT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    easter_egg = 3'b000;
    case (state_q)
      S_LOAD:  easter_egg = 3'b001;
      S_RUN:   easter_egg = 3'b010;
      S_HALT:  easter_egg = 3'b100;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      n_q         <= '0;
      ptr_q       <= '0;
      sh_q        <= '0;
      pc_q        <= '0;
      value_o     <= '0;
      is_positive <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        dmem_q[i] <= '0;
      end
    end else begin
      value_o     <= src[{vout_addr, 3'b000} +: 8];
      is_positive <= ~src[31] & (|src);
      case (state_q)
        S_CNT: if (cnt_ok) begin
          n_q   <= instr_i[6:0];
          ptr_q <= '0;
        end
        S_LOAD: begin
          ptr_q <= ptr_q + 8'd1;
          sh_q  <= {sh_q[15:0], instr_i};
          if (load_last) pc_q <= '0;
        end
        S_RUN: begin
          if (!halt) pc_q <= next_pc;
          if (wb_en && (rd != 5'd0)) regs_q[rd] <= wb_val;
          if (st_en) dmem_q[mem_addr[6:2]] <= b;
        end
        default: ;
      endcase
    end
  end

  // Instruction memory survives reset; a word is written once its fourth byte arrives.
  always_ff @(posedge clk_i) begin
    if (reset && (state_q == S_LOAD) && (ptr_q[1:0] == 2'b11))
      imem[ptr_q[7:2]] <= {sh_q, instr_i};
  end
endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
// ---------------------------------------------------------------------------
// tb_cpu: random and directed programs against an instruction-level model.
//                                                                 Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_cpu;
  logic       clk_i = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] instr_i = 8'd0;
  logic       DataOrReg = 1'b1;
  logic [4:0] address = 5'd0;
  logic [1:0] vout_addr = 2'd0;
  logic [7:0] value_o;
  logic       is_positive;
  logic [2:0] easter_egg;

  int checks = 0;
  int failures = 0;

  logic [31:0] prog   [64];
  logic [31:0] m_imem [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [32];

  cpu dut (
    .clk_i(clk_i), .reset(reset), .instr_i(instr_i), .DataOrReg(DataOrReg),
    .address(address), .vout_addr(vout_addr), .value_o(value_o),
    .is_positive(is_positive), .easter_egg(easter_egg)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_dmem[i] = 32'd0;
    end
  endfunction

  // Architectural interpreter; returns the number of instructions executed.
  function automatic int model_run(input int n);
    int unsigned pc, npc, steps, ea;
    int sa, sb, si, sbr, sj, res;
    logic [31:0] ins;
    int op, f3, f7, rd, sh;
    bit wr;
    pc = 0;
    steps = 0;
    while (steps < 10000) begin
      ins = m_imem[pc / 4];
      op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]); rd = int'(ins[11:7]);
      sa  = int'(m_regs[ins[19:15]]);
      sb  = int'(m_regs[ins[24:20]]);
      si  = int'($signed(ins[31:20]));
      sbr = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      sj  = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      sh  = int'(ins[24:20]);
      npc = pc + 4;
      wr  = 1'b0;
      res = 0;
      if (op == 'h33) begin
        wr = 1'b1;
        if      (f7 == 0    && f3 == 0) res = sa + sb;
        else if (f7 == 'h20 && f3 == 0) res = sa - sb;
        else if (f7 == 0    && f3 == 7) res = sa & sb;
        else if (f7 == 0    && f3 == 6) res = sa | sb;
        else if (f7 == 0    && f3 == 4) res = sa ^ sb;
        else if (f7 == 0    && f3 == 2) res = (sa < sb) ? 1 : 0;
        else if (f7 == 0    && f3 == 1) res = sa << (sb % 32 + (sb < 0 && sb % 32 != 0 ? 32 : 0));
        else if (f7 == 0    && f3 == 5) res = int'(int'(unsigned'(sa)) >>> 0) == 0 ? 0 : int'(unsigned'(sa) >> (unsigned'(sb) % 32));
`ifdef CPU_MUL_EN
        else if (f7 == 1    && f3 == 0) res = sa * sb;
`endif
        else wr = 1'b0;
      end else if (op == 'h13) begin
        wr = 1'b1;
        case (f3)
          0: res = sa + si;
          7: res = sa & si;
          6: res = sa | si;
          4: res = sa ^ si;
          2: res = (sa < si) ? 1 : 0;
          1: begin res = sa << sh; wr = (f7 == 0); end
          5: begin res = int'(unsigned'(sa) >> sh); wr = (f7 == 0); end
          default: wr = 1'b0;
        endcase
      end else if (op == 'h03 && f3 == 2) begin
        ea = unsigned'(sa + si);
        res = int'(m_dmem[(ea / 4) % 32]);
        wr = 1'b1;
      end else if (op == 'h23 && f3 == 2) begin
        ea = unsigned'(sa + int'($signed({ins[31:25], ins[11:7]})));
        m_dmem[(ea / 4) % 32] = unsigned'(sb);
      end else if (op == 'h63) begin
        if ((f3 == 0 && sa == sb) || (f3 == 1 && sa != sb) || (f3 == 4 && sa < sb))
          npc = pc + unsigned'(sbr);
      end else if (op == 'h6F) begin
        res = int'(pc + 4);
        wr = 1'b1;
        npc = pc + unsigned'(sj);
      end
      if (wr && rd != 0) m_regs[rd] = unsigned'(res);
      steps++;
      if (int'(npc) < 0 || (npc % 4) != 0 || npc >= unsigned'(4 * n)) break;
      pc = npc;
    end
    return int'(steps);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    instr_i = b;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset = 1'b0;
    instr_i = 8'd0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_value", {24'd0, value_o}, 32'd0);
    check("rst_pos", {31'd0, is_positive}, 32'd0);
    check("rst_state", {29'd0, easter_egg}, 32'd0);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic read_byte(input logic dor, input int addr, input int bsel,
                           output logic [7:0] v, output logic p);
    DataOrReg = dor;
    address   = addr[4:0];
    vout_addr = bsel[1:0];
    @(negedge clk_i);
    v = value_o;
    p = is_positive;
  endtask

  task automatic verify_all(input string tag);
    logic [31:0] w, e;
    logic [7:0]  v;
    logic        p;
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 32; r++) begin
        for (int bs = 0; bs < 4; bs++) begin
          read_byte(s == 1, r, bs, v, p);
          w[bs*8 +: 8] = v;
        end
        e = (s == 1) ? m_regs[r] : m_dmem[r];
        check($sformatf("%s_%s%0d", tag, (s == 1) ? "x" : "m", r), w, e);
        check($sformatf("%s_pos_%s%0d", tag, (s == 1) ? "x" : "m", r), {31'd0, p},
              {31'd0, int'(e) > 0});
      end
    end
  endtask

  task automatic run_prog(input int n, input string tag);
    int m, cyc;
    for (int i = 0; i < n; i++) m_imem[i] = prog[i];
    m = model_run(n);
    send(8'hFE);
    send(n[7:0]);
    for (int i = 0; i < n; i++)
      for (int bs = 3; bs >= 0; bs--) send(prog[i][bs*8 +: 8]);
    @(negedge clk_i);
    instr_i = 8'd0;
    check({tag, "_run_state"}, {29'd0, easter_egg}, 32'd2);
    cyc = 0;
    while (cyc < 12000 && easter_egg != 3'b100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_halt_cycles"}, cyc, m);
  endtask

  function automatic logic [31:0] rand_instr(input int pc_idx);
    int k, rd, rs1, rs2, f3;
    int f3i [7] = '{0, 7, 6, 4, 2, 1, 5};
    int rsel [10][2] = '{'{0,0}, '{'h20,0}, '{0,7}, '{0,6}, '{0,4}, '{0,2}, '{0,1}, '{0,5}, '{1,0}, '{'h20,5}};
    logic [31:0] w;
    k   = $urandom_range(0, 9);
    rd  = $urandom_range(0, 15);
    rs1 = $urandom_range(0, 15);
    rs2 = $urandom_range(0, 15);
    case (k)
      0: begin
        f3 = $urandom_range(0, 9);
        w = enc_r(rsel[f3][0], rs2, rs1, rsel[f3][1], rd);
      end
      1, 2, 3: begin
        f3 = f3i[$urandom_range(0, 6)];
        if (f3 == 1 || f3 == 5)
          w = enc_i(($urandom_range(0, 3) == 0 ? 'h400 : 0) | $urandom_range(0, 31), rs1, f3, rd, 7'h13);
        else
          w = enc_i($urandom_range(0, 4095), rs1, f3, rd, 7'h13);
      end
      4: w = enc_i($urandom_range(0, 255), rs1, 2, rd, 7'h03);
      5: w = enc_s($urandom_range(0, 255), rs2, rs1);
      6: begin
        f3 = f3i[$urandom_range(0, 6)] == 5 ? 5 : ($urandom_range(0, 2) == 2 ? 4 : $urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0:       w = enc_b(2, rs2, rs1, f3);
          1:       w = enc_b(-2048 - 4 * pc_idx, rs2, rs1, f3);
          default: w = enc_b(4 * $urandom_range(1, 3), rs2, rs1, f3);
        endcase
      end
      7: w = enc_j(($urandom_range(0, 5) == 0) ? 6 : 4 * $urandom_range(1, 3), rd);
      default: begin
        w = $urandom;
        if (w[6:0] == 7'h63 || w[6:0] == 7'h6F) w[6:0] = 7'h37;
      end
    endcase
    return w;
  endfunction

  logic [7:0] v;
  logic       p;
  int         n;

  initial begin
    model_clear();
    do_reset();
    verify_all("reset");

    prog[0] = 32'h00500413;
    prog[1] = 32'hFF940493;
    run_prog(2, "addi");
    read_byte(1'b1, 8, 0, v, p);
    check("x8_b0", {24'd0, v}, 32'h05);
    check("x8_pos", {31'd0, p}, 32'd1);
    read_byte(1'b1, 9, 3, v, p);
    check("x9_b3", {24'd0, v}, 32'hFF);
    check("x9_pos", {31'd0, p}, 32'd0);

    prog[0] = 32'h00500413;
    prog[1] = 32'h00802223;
    prog[2] = enc_i(4, 0, 2, 10, 7'h03);
    run_prog(3, "swlw");
    read_byte(1'b0, 1, 0, v, p);
    check("m1_b0", {24'd0, v}, 32'h05);
    read_byte(1'b1, 10, 0, v, p);
    check("x10_b0", {24'd0, v}, 32'h05);

    prog[0] = enc_i(7, 0, 0, 0, 7'h13);
    run_prog(1, "x0");
    read_byte(1'b1, 0, 0, v, p);
    check("x0_zero", {24'd0, v}, 32'h00);

    do_reset();
    prog[0] = enc_i(3, 0, 0, 8, 7'h13);
    prog[1] = enc_i(1, 9, 0, 9, 7'h13);
    prog[2] = enc_i(-1, 8, 0, 8, 7'h13);
    prog[3] = enc_b(-8, 0, 8, 1);
    run_prog(4, "loop");
    read_byte(1'b1, 9, 0, v, p);
    check("loop_x9", {24'd0, v}, 32'h03);
    read_byte(1'b1, 8, 0, v, p);
    check("loop_x8", {24'd0, v}, 32'h00);
    verify_all("loop");

    send(8'hFE);
    send(8'h00);
    send(8'h02);
    send(8'h11);
    @(negedge clk_i);
    check("cnt0_idle", {29'd0, easter_egg}, 32'd0);
    send(8'hFE);
    send(8'h41);
    send(8'h01);
    @(negedge clk_i);
    check("cnt65_idle", {29'd0, easter_egg}, 32'd0);

    send(8'hFE);
    send(8'h03);
    for (int i = 0; i < 5; i++) send(8'h13);
    @(negedge clk_i);
    check("midload_state", {29'd0, easter_egg}, 32'd1);
    do_reset();
    for (int i = 0; i < 6; i++) prog[i] = rand_instr(i);
    run_prog(6, "afterrst");
    verify_all("afterrst");

    do_reset();
    prog[0] = enc_i(6, 0, 0, 8, 7'h13);
    prog[1] = enc_i(7, 0, 0, 9, 7'h13);
    prog[2] = enc_r(1, 9, 8, 0, 10);
    run_prog(3, "mul");
    read_byte(1'b1, 10, 0, v, p);
`ifdef CPU_MUL_EN
    check("mul_x10", {24'd0, v}, 32'h2A);
`else
    check("mul_x10", {24'd0, v}, 32'h00);
`endif

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) prog[i] = rand_instr(i);
      run_prog(n, $sformatf("rnd%0d", t));
      verify_all($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
